tern_frame_sequencer: RTL and testbench

//  Upstream feeder for the ternary 14x7 matrix-vector multiplier. Holds the full ternary weight matrix
//  (loaded as a byte stream), then turns a stream of 2-element int8 input pairs into the multiplier's
//  per-cycle {row, VecIn, W} drive, and flags which cycles carry a valid serialised output byte.

---
 rtl/tern_frame_sequencer_pkg.sv | 38 +++
 rtl/tern_frame_sequencer_weight_bank.sv | 34 +++
 rtl/tern_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_tern_frame_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tern_frame_sequencer_pkg.sv
// Shared sizes, codes and state encoding for the ternary frame sequencer
// and its weight bank.
package tern_frame_sequencer_pkg;

    localparam int IN_LEN         = 14;
    localparam int OUT_LEN        = 7;
    localparam int BIT_WIDTH      = 8;
    localparam int ROWS_PER_FRAME = IN_LEN / 2;
    localparam int BYTES_PER_ROW  = 4;
    localparam int LOAD_BYTES     = ROWS_PER_FRAME * BYTES_PER_ROW;
    localparam int PAIR_WIDTH     = 2 * BIT_WIDTH;

    // One slot holds two elements' worth of 2-bit weights across all columns.
    localparam int W_WIDTH        = 2 * 2 * OUT_LEN;

    localparam logic [2:0] ROW_BUBBLE = 3'd7;

    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // 2'b10 is an unused encoding and reads as zero.
    function automatic int tern_value(input logic [1:0] code);
        case (code)
            T_POS:   return 1;
            T_NEG:   return -1;
            T_ZERO:  return 0;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/tern_frame_sequencer_weight_bank.sv
// 7 x 28-bit weight register file: byte-lane write port, one combinational
// read port indexed by frame row.
module tern_frame_sequencer_weight_bank
    import tern_frame_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [2:0]         slot,
    input  logic [1:0]         lane,
    input  logic [7:0]         data,
    input  logic [2:0]         rd_row,
    output logic [W_WIDTH-1:0] rd_data
);

    localparam logic [2:0] NUM_SLOTS = 3'(ROWS_PER_FRAME);

    logic [W_WIDTH-1:0] mem [ROWS_PER_FRAME];

    // Contents are intentionally left unreset; they are meaningless until loaded.
    // Lane 3 only carries the top nibble of a slot, its upper four bits are discarded.
    always_ff @(posedge clk) begin
        if (we && (slot < NUM_SLOTS)) begin
            case (lane)
                2'd0:    mem[slot][7:0]           <= data;
                2'd1:    mem[slot][15:8]          <= data;
                2'd2:    mem[slot][23:16]         <= data;
                default: mem[slot][W_WIDTH-1:24]  <= data[3:0];
            endcase
        end
    end

    assign rd_data = (rd_row < NUM_SLOTS) ? mem[rd_row] : '0;

endmodule

// File: rtl/tern_frame_sequencer.sv
// Feeds the ternary 14x7 matrix-vector multiplier: loads the weight matrix as a
// byte stream, then issues one {row, vec, weights} drive per accepted input pair.
module tern_frame_sequencer
    import tern_frame_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  w_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAIR_WIDTH-1:0] in_pair,
    output logic [2:0]            row_out,
    output logic [PAIR_WIDTH-1:0] vec_out,
    output logic [W_WIDTH-1:0]    w_out,
    output logic                  out_valid,
    output logic [2:0]            out_col,
    output logic                  drop_err
);

    localparam logic [4:0] LAST_BYTE = 5'(LOAD_BYTES - 1);
    localparam logic [2:0] LAST_ROW  = 3'(ROWS_PER_FRAME - 1);
    localparam logic [2:0] LAST_COL  = 3'(OUT_LEN - 1);

    state_t             state;
    state_t             next_state;
    logic [4:0]         byte_cnt;
    logic [2:0]         row_cnt;
    logic               byte_we;
    logic               accept;
    logic [W_WIDTH-1:0] bank_data;

    tern_frame_sequencer_weight_bank u_bank (
        .clk     (clk),
        .we      (byte_we),
        .slot    (byte_cnt[4:2]),
        .lane    (byte_cnt[1:0]),
        .data    (load_byte),
        .rd_row  (row_cnt),
        .rd_data (bank_data)
    );

    assign in_ready = (state == ST_RUN);
    assign w_ready  = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // cfg_start overrides everything, including a byte or pair offered in the same cycle.
    always_comb begin
        next_state = state;
        byte_we    = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                if (load_valid) begin
                    byte_we = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                accept = in_valid;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (cfg_start) begin
            next_state = ST_LOAD;
            byte_we    = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cfg_start) begin
            byte_cnt <= '0;
            row_cnt  <= '0;
            drop_err <= 1'b0;
        end else begin
            if (byte_we) begin
                byte_cnt <= (byte_cnt == LAST_BYTE) ? 5'd0 : byte_cnt + 5'd1;
            end
            if (accept) begin
                row_cnt <= (row_cnt == LAST_ROW) ? 3'd0 : row_cnt + 3'd1;
            end
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Non-accept cycles drive a bubble: zero weights on a row code that neither
    // clears nor unloads the multiplier, so a frame may pause anywhere.
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            row_out <= ROW_BUBBLE;
            vec_out <= '0;
            w_out   <= '0;
        end else begin
            row_out <= row_cnt;
            vec_out <= in_pair;
            w_out   <= bank_data;
        end
    end

    // Runs independently of the FSM so a latched result drains through a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_col   <= '0;
        end else if (row_out == LAST_ROW) begin
            out_valid <= 1'b1;
            out_col   <= '0;
        end else if (out_valid) begin
            if (out_col == LAST_COL) begin
                out_valid <= 1'b0;
                out_col   <= '0;
            end else begin
                out_col <= out_col + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tern_frame_sequencer.sv
// Directed bench for tern_frame_sequencer with a small behavioural model of the
// downstream multiplier, used to turn the drive stream into column results.
module tb_tern_frame_sequencer;
    import tern_frame_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        w_ready;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pair;
    logic [2:0]  row_out;
    logic [15:0] vec_out;
    logic [27:0] w_out;
    logic        out_valid;
    logic [2:0]  out_col;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] slots   [7];
    logic [15:0] pairs   [7];
    logic [7:0]  exp_col [7];
    int          acc     [7];
    int          res     [7];

    tern_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .w_ready    (w_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pair    (in_pair),
        .row_out    (row_out),
        .vec_out    (vec_out),
        .w_out      (w_out),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    function automatic int colSum(input logic [15:0] v, input logic [27:0] w, input int c);
        return int'($signed(v[7:0])) * tern_value(w[2*c +: 2])
             + int'($signed(v[15:8])) * tern_value(w[14 + 2*c +: 2]);
    endfunction

    // Multiplier model: row 0 restarts the sums, row 6 latches the column results.
    always @(posedge clk) begin
        if (row_out != ROW_BUBBLE) begin
            for (int c = 0; c < 7; c++) begin
                acc[c] <= ((row_out == 3'd0) ? 0 : acc[c]) + colSum(vec_out, w_out, c);
                if (row_out == 3'd6) begin
                    res[c] <= acc[c] + colSum(vec_out, w_out, c);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic lv, input logic [7:0] lb,
                                 input logic iv, input logic [15:0] ip);
        cfg_start  = c;
        load_valid = lv;
        load_byte  = lb;
        in_valid   = iv;
        in_pair    = ip;
        @(posedge clk);
        #1;
    endtask

    task automatic loadBank(input logic byte_with_cfg);
        logic [31:0] s;
        applyStimulus(1'b1, byte_with_cfg, 8'hAA, 1'b0, 16'h0);
        checkOutput("load_wready0", 32'(w_ready), 32'd0);
        checkOutput("load_row_bubble", 32'(row_out), 32'd7);
        for (int k = 0; k < 28; k++) begin
            s = slots[k / 4];
            applyStimulus(1'b0, 1'b1, s[8*(k % 4) +: 8], 1'b0, 16'h0);
            if (k == 26) checkOutput("wready_early", 32'(w_ready), 32'd0);
            if (k == 27) begin
                checkOutput("wready_done", 32'(w_ready), 32'd1);
                checkOutput("inready_done", 32'(in_ready), 32'd1);
            end
        end
    endtask

    task automatic runFrame(input int gap_row, input logic cfg_in_drain, input logic chk_res);
        int v;
        logic [31:0] s;
        for (int r = 0; r < 7; r++) begin
            applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, pairs[r]);
            s = slots[r];
            checkOutput("row_out", 32'(row_out), 32'(r));
            checkOutput("vec_out", 32'(vec_out), 32'(pairs[r]));
            checkOutput("w_out", 32'(w_out), 32'(s[27:0]));
            if (r == gap_row) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 16'h0);
                    checkOutput("gap_row", 32'(row_out), 32'd7);
                    checkOutput("gap_w", 32'(w_out), 32'd0);
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            applyStimulus(cfg_in_drain && (k == 0), 1'b0, 8'h0, 1'b0, 16'h0);
            if (cfg_in_drain && (k == 0)) checkOutput("drain_cfg_wready", 32'(w_ready), 32'd0);
            checkOutput("out_valid", 32'(out_valid), 32'd1);
            checkOutput("out_col", 32'(out_col), 32'(k));
            if (chk_res) begin
                v = res[int'(out_col)];
                checkOutput("vecout", 32'(v[7:0]), 32'(exp_col[k]));
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 16'h0);
        checkOutput("out_valid_end", 32'(out_valid), 32'd0);
    endtask

    task automatic setIdentity();
        slots[0] = 32'h0001_0001;
        slots[1] = 32'h0010_0010;
        slots[2] = 32'h0100_0100;
        slots[3] = 32'h0000_1000;
        for (int r = 4; r < 7; r++) slots[r] = 32'h0;
        for (int r = 0; r < 7; r++) pairs[r] = {8'(2*r + 2), 8'(2*r + 1)};
        for (int c = 0; c < 7; c++) exp_col[c] = 8'(c + 1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 16'h0);
        checkOutput("rst_row", 32'(row_out), 32'd7);
        checkOutput("rst_wready", 32'(w_ready), 32'd0);
        checkOutput("rst_inready", 32'(in_ready), 32'd0);
        checkOutput("rst_outvalid", 32'(out_valid), 32'd0);
        checkOutput("rst_vec", 32'(vec_out), 32'd0);
        checkOutput("rst_dropErr", 32'(drop_err), 32'd0);
        rst = 1'b0;

        // Bytes 0x00..0x1B, so slot r reads back as bytes 4r..4r+3.
        for (int r = 0; r < 7; r++) begin
            slots[r] = {8'(4*r + 3), 8'(4*r + 2), 8'(4*r + 1), 8'(4*r)};
            pairs[r] = 16'h1234 + 16'(r);
        end
        loadBank(1'b0);
        runFrame(-1, 1'b0, 1'b0);

        setIdentity();
        loadBank(1'b0);
        runFrame(-1, 1'b0, 1'b1);
        runFrame(2, 1'b0, 1'b1);

        for (int r = 0; r < 7; r++) begin
            slots[r] = 32'hFFFF_FFFF;
            pairs[r] = 16'h1010;
            exp_col[r] = 8'h20;
        end
        loadBank(1'b0);
        runFrame(-1, 1'b1, 1'b1);

        setIdentity();
        loadBank(1'b0);
        for (int r = 0; r < 3; r++) applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, pairs[r]);
        applyStimulus(1'b1, 1'b0, 8'h0, 1'b1, pairs[3]);
        checkOutput("abort_row", 32'(row_out), 32'd7);
        checkOutput("abort_wready", 32'(w_ready), 32'd0);
        checkOutput("abort_dropErr", 32'(drop_err), 32'd0);
        for (int r = 0; r < 7; r++) begin
            slots[r] = 32'h0555_5555;
            exp_col[r] = 8'h69;
        end
        loadBank(1'b1);
        runFrame(-1, 1'b0, 1'b1);

        for (int r = 0; r < 3; r++) applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, pairs[r]);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, pairs[3]);
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, pairs[4]);
        checkOutput("midrun_rst_row", 32'(row_out), 32'd7);
        checkOutput("midrun_rst_wready", 32'(w_ready), 32'd0);
        checkOutput("midrun_rst_outvalid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, 16'h0);
        checkOutput("drop_set", 32'(drop_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 16'h0);
        checkOutput("drop_sticky", 32'(drop_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h0, 1'b0, 16'h0);
        checkOutput("drop_clear", 32'(drop_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
